eth_tx_arbiter: RTL
===================

Name: eth_tx_arbiter

Overview:
Shares the single Ethernet UDP transmit engine (RGMII PHY1 path) between two requesters: the 2-bit command sender and the picture sender. It grants one requester at a time and issues a one-cycle start pulse to the engine. It then waits for the engine's completion and returns a per-requester done pulse. A watchdog timeout protects the link, and a starvation guard stops command traffic from blocking picture traffic indefinitely. It sits between the top-level mode FSM and the transmit engine.

Parameters:
TIMEOUT_CYCLES, 50_000_000, max cycles in a grant before abort (1 s at 50 MHz); must be >= 2.
GAP_CYCLES, 16, idle cycles enforced after each transfer before the next grant; 0 allowed.
MAX_CMD_BURST, 4, consecutive cmd grants won while pic_req is pending before pic is forced to win; >= 1.

Ports:
sys_clk     in   1  50 MHz system clock
rst_n       in   1  asynchronous active-low reset
cmd_req     in   1  cmd requester wants the engine; held until cmd_done
cmd_gnt     out  1  cmd owns the engine
cmd_done    out  1  1-cycle pulse, cmd transfer finished or aborted
pic_req     in   1  picture requester wants the engine; held until pic_done
pic_gnt     out  1  pic owns the engine
pic_done    out  1  1-cycle pulse, pic transfer finished or aborted
tx_start    out  1  1-cycle pulse to engine, start frame
tx_sel      out  1  engine data mux select: 0 = cmd, 1 = pic; stable while granted
tx_done     in   1  engine completion pulse
timeout_err out  1  1-cycle pulse, grant aborted by watchdog
busy        out  1  high in any state other than IDLE

Behaviour:
- Clock and reset are decided: one clock, sys_clk; reset rst_n is asynchronous, active-low.
- Reset, asserted at any time, including mid-transfer:
  - All outputs are 0.
  - State is IDLE.
  - Timeout, gap and streak counters are 0.
  - No done pulse is emitted for an in-flight transfer.
- States: IDLE, GRANT, GAP.
- IDLE, arbitration on each edge where (cmd_req | pic_req):
  - Winner is pic if pic_req && (!cmd_req || streak == MAX_CMD_BURST); otherwise cmd.
  - Registered outputs: on the cycle after the sampling edge, the winner's gnt=1, tx_sel=winner, tx_start=1 (for that single cycle), busy=1.
  - Latency: req sampled at edge N → gnt/tx_start visible after edge N.
- Streak counter, updated at each arbitration:
  - Cmd wins with pic_req=1: streak increments, saturating at MAX_CMD_BURST.
  - Cmd wins with pic_req=0: streak clears.
  - Pic wins: streak clears.
  - Width is clog2(MAX_CMD_BURST+1).
- GRANT:
  - Watchdog counts from 0 on entry.
  - tx_done=1: next cycle gnt=0 and the owner's done pulses once; go to GAP, or to IDLE if GAP_CYCLES=0.
  - Counter reaches TIMEOUT_CYCLES-1 without tx_done: the owner's done and timeout_err pulse together; exit as above.
  - tx_done on the same edge as the timeout terminal count: treated as success, no timeout_err.
  - Requester deasserting req mid-grant is ignored; the transfer runs to tx_done or timeout.
  - tx_sel holds until the gnt falling edge.
- GAP:
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
  - Requests are not sampled during GAP.
  - tx_done arriving in GAP or IDLE is ignored (no done pulse, no state change).
- Back-to-back:
  - Requester holds req and re-asserts after done: earliest new tx_start is GAP_CYCLES+1 cycles after the done pulse, or 1 cycle after when GAP_CYCLES=0.
- Invariants:
  - cmd_gnt & pic_gnt is never 1.
  - tx_start only ever occurs on the first cycle of a grant.
  - At most one done pulse per grant.

Decomposition:
- Shared package eth_ctrl_pkg:
  - State encoding localparams ST_IDLE / ST_GRANT / ST_GAP.
  - Requester IDs SEL_CMD=1'b0, SEL_PIC=1'b1.
  - Default timeout constant.
- One natural sub-module, tx_watchdog: a loadable down-counter with clear/enable/expire. It is reused later for the SD read path.
- The arbiter FSM and streak logic stay in eth_tx_arbiter.

Test Plan:
- Single cmd: cmd_req=1 at cycle 10, tx_done at cycle 40 → cmd_gnt=1 and tx_start pulse at cycle 11, tx_sel=0; cmd_done pulse at 41; busy low at 41+16.
- Simultaneous req, MAX_CMD_BURST=4: cmd_req and pic_req held high → cmd wins 4 times, pic wins the 5th grant; after the pic grant, cmd wins next (streak cleared); never both gnt.
- Timeout, TIMEOUT_CYCLES=100: pic grant with no tx_done → pic_done and timeout_err pulse together exactly 100 cycles after grant entry; tx_done==terminal edge → no timeout_err.
- Spurious/early events: tx_done pulsed in IDLE and in GAP → no done pulse, no state change; req dropped mid-grant → grant persists until tx_done.
- Reset mid-grant: rst_n low at cycle 25 of a cmd grant → all outputs 0 asynchronously, no cmd_done; after release, a fresh request is granted with 1-cycle latency.
- GAP_CYCLES=0 back-to-back: pic_req held, three transfers → new tx_start exactly 1 cycle after each pic_done.

Source files
------------

// File: rtl/eth_ctrl_pkg.sv
// eth_ctrl_pkg
// Shared definitions for the Ethernet transmit control path: arbiter state
// encoding, requester identifiers and default timing constants, plus a small
// helper that sizes counters so they can hold a given maximum value.
package eth_ctrl_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Requester identifiers, also used directly as the engine data mux select
    localparam logic SEL_CMD = 1'b0;
    localparam logic SEL_PIC = 1'b1;

    // One second at the 50 MHz system clock
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50_000_000;
    localparam int unsigned DEFAULT_GAP_CYCLES     = 16;
    localparam int unsigned DEFAULT_MAX_CMD_BURST  = 4;

    // Bits needed to represent 0..max_value; never less than one bit so that
    // counters for a zero-valued parameter still have a legal width.
    function automatic int unsigned width_for(input int unsigned max_value);
        if (max_value == 0)
            width_for = 1;
        else
            width_for = $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/tx_watchdog.sv
// tx_watchdog
// Loadable down-counter used as a transfer watchdog. Load it with the number
// of cycles minus one when a transfer starts, enable it while the transfer is
// in flight, and watch expire, which is high whenever the count sits at zero.
// The counter stops at zero rather than wrapping.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset, clears the count
//   clear       synchronous clear to zero (highest priority)
//   load        synchronous load of load_value
//   load_value  value loaded on load
//   enable      decrement by one per cycle while non-zero
//   expire      count is zero
module tx_watchdog #(
    parameter int unsigned WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // Clear beats load, load beats the decrement; holding at zero keeps
    // expire asserted until the owner reloads or clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && (count != '0))
            count <= count - WIDTH'(1);
    end

    assign expire = (count == '0);

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Shares the single UDP transmit engine between the command sender and the
// picture sender. One requester is granted at a time; the engine receives a
// one-cycle start pulse on the first grant cycle, and the owner receives a
// one-cycle done pulse when the engine finishes or the watchdog aborts the
// grant. A fixed idle gap follows every transfer. Command traffic can win at
// most MAX_CMD_BURST consecutive grants while a picture request is waiting.
//
// Ports:
//   sys_clk      50 MHz system clock
//   rst_n        asynchronous active-low reset
//   cmd_req      command requester wants the engine (held until cmd_done)
//   cmd_gnt      command requester owns the engine
//   cmd_done     one-cycle pulse, command transfer finished or aborted
//   pic_req      picture requester wants the engine (held until pic_done)
//   pic_gnt      picture requester owns the engine
//   pic_done     one-cycle pulse, picture transfer finished or aborted
//   tx_start     one-cycle start pulse to the engine
//   tx_sel       engine data mux select, 0 = cmd, 1 = pic
//   tx_done      engine completion pulse
//   timeout_err  one-cycle pulse, grant aborted by the watchdog
//   busy         arbiter is not idle
module eth_tx_arbiter
    import eth_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int unsigned MAX_CMD_BURST  = DEFAULT_MAX_CMD_BURST
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic cmd_req,
    output logic cmd_gnt,
    output logic cmd_done,
    input  logic pic_req,
    output logic pic_gnt,
    output logic pic_done,
    output logic tx_start,
    output logic tx_sel,
    input  logic tx_done,
    output logic timeout_err,
    output logic busy
);

    localparam int unsigned WD_W  = width_for(TIMEOUT_CYCLES - 1);
    localparam int unsigned ST_W  = width_for(MAX_CMD_BURST);
    localparam int unsigned GAP_W = width_for(GAP_CYCLES);

    localparam logic [WD_W-1:0]  WD_LOAD    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0]  STREAK_MAX = ST_W'(MAX_CMD_BURST);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    arb_state_t       state, state_n;
    logic             cmd_gnt_n, pic_gnt_n, tx_start_n, tx_sel_n;
    logic             cmd_done_n, pic_done_n, timeout_err_n;
    logic [ST_W-1:0]  streak, streak_n;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
    logic             wd_load, wd_clear, wd_enable, wd_expire;
    logic             pic_wins;

    // Picture wins when it is the only requester, or when command has already
    // taken its full burst of grants while picture was waiting.
    assign pic_wins  = pic_req && (!cmd_req || (streak == STREAK_MAX));
    assign wd_enable = (state == ST_GRANT);
    assign busy      = (state != ST_IDLE);

    tx_watchdog #(
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .clear      (wd_clear),
        .load       (wd_load),
        .load_value (WD_LOAD),
        .enable     (wd_enable),
        .expire     (wd_expire)
    );

    // State, registered outputs and counters. Everything here is cleared by
    // reset, which also drops any in-flight transfer without a done pulse.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_gnt     <= 1'b0;
            pic_gnt     <= 1'b0;
            tx_start    <= 1'b0;
            tx_sel      <= 1'b0;
            cmd_done    <= 1'b0;
            pic_done    <= 1'b0;
            timeout_err <= 1'b0;
            streak      <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            cmd_gnt     <= cmd_gnt_n;
            pic_gnt     <= pic_gnt_n;
            tx_start    <= tx_start_n;
            tx_sel      <= tx_sel_n;
            cmd_done    <= cmd_done_n;
            pic_done    <= pic_done_n;
            timeout_err <= timeout_err_n;
            streak      <= streak_n;
            gap_cnt     <= gap_cnt_n;
        end
    end

    // Next-state and next-output logic. Pulses default low; grants, select,
    // streak and gap counter hold unless a state transition changes them.
    always_comb begin
        state_n       = state;
        cmd_gnt_n     = cmd_gnt;
        pic_gnt_n     = pic_gnt;
        tx_sel_n      = tx_sel;
        tx_start_n    = 1'b0;
        cmd_done_n    = 1'b0;
        pic_done_n    = 1'b0;
        timeout_err_n = 1'b0;
        streak_n      = streak;
        gap_cnt_n     = gap_cnt;
        wd_load       = 1'b0;
        wd_clear      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_req || pic_req) begin
                    state_n    = ST_GRANT;
                    tx_start_n = 1'b1;
                    wd_load    = 1'b1;
                    if (pic_wins) begin
                        pic_gnt_n = 1'b1;
                        tx_sel_n  = SEL_PIC;
                        streak_n  = '0;
                    end else begin
                        cmd_gnt_n = 1'b1;
                        tx_sel_n  = SEL_CMD;
                        if (!pic_req)
                            streak_n = '0;
                        else if (streak != STREAK_MAX)
                            streak_n = streak + ST_W'(1);
                    end
                end
            end

            // A completion on the watchdog's terminal edge still counts as a
            // success, so timeout_err is only raised when tx_done is absent.
            ST_GRANT: begin
                if (tx_done || wd_expire) begin
                    cmd_gnt_n     = 1'b0;
                    pic_gnt_n     = 1'b0;
                    cmd_done_n    = cmd_gnt;
                    pic_done_n    = pic_gnt;
                    timeout_err_n = !tx_done;
                    wd_clear      = 1'b1;
                    gap_cnt_n     = '0;
                    state_n       = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_n = ST_IDLE;
                else
                    gap_cnt_n = gap_cnt + GAP_W'(1);
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule
